// File: rtl/pwm_pkg.sv
// Shared PWM definitions: scheduler FSM states and default timing constants
// used by the PWM generator, clock divider and duty scheduler.
package pwm_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } sched_state_e;

  localparam int unsigned BASE_FREQ     = 32'd50_000_000;
  localparam int unsigned TARGET_FREQ   = 32'd50;
  localparam int unsigned PERIOD_COUNTS = BASE_FREQ / TARGET_FREQ;
  localparam int unsigned CNT_W         = 32'd32;

endpackage

// File: rtl/pwm_duty_scheduler_duty_step_sat.sv
// Combinational saturating step of the target duty value, clamped to
// [0, PERIOD_COUNTS]; simultaneous or absent requests leave it unchanged.
module duty_step_sat #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned PERIOD_COUNTS = 1_000_000,
  parameter int unsigned STEP_COUNTS   = 50_000
) (
  input  logic [CNT_W-1:0] target_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] target_o
);

  localparam logic [CNT_W:0]   PERIOD_W = (CNT_W+1)'(PERIOD_COUNTS);
  localparam logic [CNT_W:0]   STEP_W   = (CNT_W+1)'(STEP_COUNTS);
  localparam logic [CNT_W-1:0] PERIOD_N = CNT_W'(PERIOD_COUNTS);
  localparam logic [CNT_W-1:0] STEP_N   = CNT_W'(STEP_COUNTS);

  logic [CNT_W:0] sum_s;

  // Extra sum bit keeps the clamp correct even when target is near 2^CNT_W.
  always_comb begin
    sum_s    = {1'b0, target_i} + STEP_W;
    target_o = target_i;
    if (inc_i && !dec_i) begin
      if (sum_s > PERIOD_W) begin
        target_o = PERIOD_N;
      end else begin
        target_o = sum_s[CNT_W-1:0];
      end
    end else if (dec_i && !inc_i) begin
      if (target_i < STEP_N) begin
        target_o = '0;
      end else begin
        target_o = target_i - STEP_N;
      end
    end else begin
      target_o = target_i;
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Duty scheduler: accumulates button requests into a saturated target and
// commits it to the PWM compare register only at period boundaries.
module pwm_duty_scheduler #(
  parameter int unsigned PERIOD_COUNTS = pwm_pkg::PERIOD_COUNTS,
  parameter int unsigned STEP_COUNTS   = 32'd50_000,
  parameter int unsigned INIT_DC       = PERIOD_COUNTS / 32'd2,
  parameter int unsigned CNT_W         = pwm_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_req,
  input  logic             dec_req,
  input  logic             period_wrap,
  output logic [CNT_W-1:0] dc_cmp,
  output logic             dc_update,
  output logic             pending,
  output logic             at_max,
  output logic             at_min
);

  import pwm_pkg::*;

  localparam logic [CNT_W-1:0] PERIOD_N = CNT_W'(PERIOD_COUNTS);
  localparam logic [CNT_W-1:0] INIT_N   = CNT_W'(INIT_DC);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] dc_cmp_q, dc_cmp_d;
  logic             dc_update_q, dc_update_d;
  logic             at_max_q, at_min_q;

  duty_step_sat #(
    .CNT_W         (CNT_W),
    .PERIOD_COUNTS (PERIOD_COUNTS),
    .STEP_COUNTS   (STEP_COUNTS)
  ) u_step (
    .target_i (target_q),
    .inc_i    (inc_req),
    .dec_i    (dec_req),
    .target_o (target_d)
  );

  // Commit uses the pre-request target; pending reflects the post-request one.
  always_comb begin
    dc_cmp_d    = dc_cmp_q;
    dc_update_d = 1'b0;
    state_d     = IDLE;
    case (state_q)
      IDLE: begin
        dc_cmp_d = dc_cmp_q;
      end
      PENDING: begin
        if (period_wrap) begin
          dc_cmp_d    = target_q;
          dc_update_d = 1'b1;
        end else begin
          dc_cmp_d = dc_cmp_q;
        end
      end
      default: begin
        dc_cmp_d = dc_cmp_q;
      end
    endcase
    if (target_d != dc_cmp_d) begin
      state_d = PENDING;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      target_q    <= INIT_N;
      dc_cmp_q    <= INIT_N;
      dc_update_q <= 1'b0;
      at_max_q    <= (INIT_N == PERIOD_N);
      at_min_q    <= (INIT_N == '0);
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      dc_cmp_q    <= dc_cmp_d;
      dc_update_q <= dc_update_d;
      at_max_q    <= (target_d == PERIOD_N);
      at_min_q    <= (target_d == '0);
    end
  end

  assign dc_cmp    = dc_cmp_q;
  assign dc_update = dc_update_q;
  assign pending   = (state_q == PENDING);
  assign at_max    = at_max_q;
  assign at_min    = at_min_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Self-checking bench for pwm_duty_scheduler: directed scenarios plus random
// requests/wraps compared against a target/compare-value reference model.
module tb_pwm_duty_scheduler;

  localparam longint PERIOD = 64'd1_000_000;
  localparam longint STEP   = 64'd50_000;
  localparam longint INIT   = 64'd500_000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inc_req = 1'b0;
  logic        dec_req = 1'b0;
  logic        period_wrap = 1'b0;
  logic [31:0] dc_cmp;
  logic        dc_update;
  logic        pending;
  logic        at_max;
  logic        at_min;

  int n_pass  = 0;
  int n_total = 0;
  int upd_cnt = 0;

  longint m_t, m_dc;
  bit     m_upd;

  pwm_duty_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .inc_req     (inc_req),
    .dec_req     (dec_req),
    .period_wrap (period_wrap),
    .dc_cmp      (dc_cmp),
    .dc_update   (dc_update),
    .pending     (pending),
    .at_max      (at_max),
    .at_min      (at_min)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_init();
    m_t = INIT; m_dc = INIT; m_upd = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dc_cmp"},    longint'(dc_cmp), m_dc);
    chk({tag, ".dc_update"}, longint'(dc_update), longint'(m_upd));
    chk({tag, ".pending"},   longint'(pending), longint'(m_t != m_dc));
    chk({tag, ".at_max"},    longint'(at_max), longint'(m_t == PERIOD));
    chk({tag, ".at_min"},    longint'(at_min), longint'(m_t == 64'd0));
  endtask

  // One clock: drive requests, advance the reference model, check after the edge.
  task automatic step(input bit inc, input bit dec, input bit wrap);
    longint nt;
    inc_req = inc; dec_req = dec; period_wrap = wrap;
    @(posedge clk);
    nt = m_t;
    if (inc && !dec) nt = (m_t + STEP > PERIOD) ? PERIOD : m_t + STEP;
    else if (dec && !inc) nt = (m_t < STEP) ? 64'd0 : m_t - STEP;
    m_upd = wrap && (m_t != m_dc);
    if (m_upd) m_dc = m_t;
    m_t = nt;
    #1;
    inc_req = 1'b0; dec_req = 1'b0; period_wrap = 1'b0;
    if (dc_update) upd_cnt++;
    check_all("step");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_init();
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    upd_cnt = 0;
  endtask

  initial begin
    model_init();
    #12;
    do_reset();
    chk("rst_dc_cmp", longint'(dc_cmp), INIT);
    chk("rst_pending", longint'(pending), 64'd0);
    chk("rst_dc_update", longint'(dc_update), 64'd0);

    // single inc, wrap 100 cycles later
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("inc_commit", longint'(dc_cmp), 64'd550_000);
    chk("inc_upd_pulse", longint'(dc_update), 64'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("inc_upd_once", longint'(upd_cnt), 64'd1);

    // three inc + one dec, single commit
    do_reset();
    step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("accum_commit", longint'(dc_cmp), 64'd600_000);
    chk("accum_upd_cnt", longint'(upd_cnt), 64'd1);

    // saturation high and low
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("sat_max_dc", longint'(dc_cmp), PERIOD);
    chk("sat_max_flag", longint'(at_max), 64'd1);
    upd_cnt = 0;
    step(1'b1, 1'b0, 1'b0);
    chk("sat_max_pending", longint'(pending), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("sat_max_no_upd", longint'(upd_cnt), 64'd0);
    for (int i = 0; i < 22; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("sat_min_dc", longint'(dc_cmp), 64'd0);
    chk("sat_min_flag", longint'(at_min), 64'd1);
    upd_cnt = 0;
    step(1'b0, 1'b1, 1'b0);
    chk("sat_min_pending", longint'(pending), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("sat_min_no_upd", longint'(upd_cnt), 64'd0);

    // simultaneous inc/dec; inc coincident with wrap
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    chk("both_pending", longint'(pending), 64'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("wrapinc_dc", longint'(dc_cmp), 64'd550_000);
    chk("wrapinc_pending", longint'(pending), 64'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("wrapinc_dc2", longint'(dc_cmp), 64'd600_000);

    // change then restore before wrap
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("restore_pending", longint'(pending), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("restore_no_upd", longint'(upd_cnt), 64'd0);

    // reset while pending
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_pre_pending", longint'(pending), 64'd1);
    rst = 1'b0;
    #1;
    model_init();
    chk("midrst_dc", longint'(dc_cmp), INIT);
    chk("midrst_pending", longint'(pending), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    upd_cnt = 0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("midrst_no_upd", longint'(upd_cnt), 64'd0);
    chk("midrst_dc_after", longint'(dc_cmp), INIT);

    // randomized requests and wraps
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
           ($urandom_range(7, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_duty_scheduler.md
# pwm_duty_scheduler

Controller for the PWM duty-cycle datapath. Converts single-cycle increment/decrement requests from the debounced front-panel buttons into a saturated target duty value and commits that value to the PWM compare register only at period boundaries, so the output never sees a glitched or truncated period. It sits between the button debouncers and the PWM counter/comparator and is the single owner of the compare value.

## Interface
- PERIOD_COUNTS, 1_000_000, clock cycles per PWM period (50 MHz / 50 Hz); also the maximum duty value (100 %).
- STEP_COUNTS, 50_000, duty change per accepted request (5 % of the default period).
- INIT_DC, PERIOD_COUNTS/2, duty value loaded at reset.
- CNT_W, 32, width of all duty/count values.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset; assertion (0) resets all state immediately; release is synchronous to clk.
- inc_req  in  1  one-cycle pulse: raise target duty by STEP_COUNTS.
- dec_req  in  1  one-cycle pulse: lower target duty by STEP_COUNTS.
- period_wrap  in  1  one-cycle pulse from the PWM counter in its last count of a period (count == PERIOD_COUNTS-1).
- dc_cmp  out  CNT_W  active compare value used by the PWM comparator; pwm_out is high while count < dc_cmp.
- dc_update  out  1  one-cycle pulse in the cycle dc_cmp takes a new value.
- pending  out  1  target differs from dc_cmp, commit awaiting period_wrap.
- at_max  out  1  target == PERIOD_COUNTS.
- at_min  out  1  target == 0.

## Operation
- Internal registers: target (CNT_W), dc_cmp (CNT_W), FSM state.
- Request decode per cycle: inc only -> target <= min(target + STEP_COUNTS, PERIOD_COUNTS); dec only -> target <= (target < STEP_COUNTS) ? 0 : target - STEP_COUNTS; both or neither -> target unchanged.
- Arithmetic: compute the sum in CNT_W+1 bits before clamping; the decrement compares before subtracting, so no wrap-around occurs at either end.
- FSM states:
  - IDLE: target == dc_cmp. Goes to PENDING when target changes to a value different from dc_cmp.
  - PENDING: waiting for period_wrap. On period_wrap, dc_cmp <= target and dc_update pulses; the FSM returns to IDLE unless a request in that same cycle moves target away from the committed value, in which case it stays in PENDING.
- Several requests within one period accumulate in target; only the final value is committed at the wrap.
- A request that changes target and then a later request that restores it to dc_cmp before the wrap returns the FSM to IDLE; no dc_update is issued.
- Wrap and request in the same cycle: the commit uses target as registered before that cycle. The request's effect is committed at the following wrap.
- Saturated requests (inc at max, dec at min) are ignored: no state change and no pending.
- period_wrap in IDLE: no action.

## Timing
- Reset values: target = INIT_DC, dc_cmp = INIT_DC, state IDLE, dc_update = 0, pending = 0, at_max = (INIT_DC == PERIOD_COUNTS), at_min = (INIT_DC == 0).
- Request at cycle n -> target, pending, at_max and at_min are valid at n+1.
- period_wrap at cycle w while pending -> dc_cmp is new at w+1 and dc_update = 1 for exactly cycle w+1, so the new duty applies to the period starting at w+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-PENDING discards the uncommitted target; reset asserted during a dc_update cycle clears the pulse.

## Structure
- Shared package pwm_pkg: the FSM state enum (IDLE, PENDING), default BASE_FREQ 50_000_000, TARGET_FREQ 50, and derived PERIOD_COUNTS, shared with the PWM generator and clock divider.
- One sub-module, duty_step_sat: combinational saturating add/subtract of STEP_COUNTS with clamping to [0, PERIOD_COUNTS].

## Test plan
- Reset with defaults -> dc_cmp = 500_000, pending = 0, dc_update = 0. One inc_req, then period_wrap 100 cycles later -> dc_cmp = 550_000 one cycle after the wrap, with a single dc_update pulse.
- Three inc_req plus one dec_req inside one period -> a single commit of 600_000 at the wrap, and exactly one dc_update.
- Drive 12 inc_req, each followed by a wrap -> dc_cmp stops at 1_000_000 and at_max = 1. A further inc_req -> pending stays 0 and there is no dc_update. Mirror this with dec_req down to 0 and at_min = 1.
- inc_req and dec_req in the same cycle -> target unchanged, no pending. inc_req in the same cycle as period_wrap, with an earlier inc already pending -> commit 550_000 now and 600_000 at the next wrap.
- inc_req then dec_req before the wrap -> pending returns to 0 and no dc_update occurs at the wrap.
- rst driven low while PENDING (target 550_000) -> dc_cmp and target return to 500_000 immediately, and no dc_update pulses after rst is released.
